// File: rtl/fetch_pc_stage.sv
// rtl/fetch_pc_stage.sv - DLX program counter and IF/ID pipeline register with stall, redirect squash and trap halt
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h11,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Redirect outranks stall so a resolved branch is never lost behind a hazard freeze.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (redirect) begin
      pc_d    = redirect_target & 32'hFFFF_FFFC;
      instr_d = NOP_INSTR;
      pcp4_d  = 32'd0;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (!stall) begin
      if (state_q == RUN) begin
        instr_d = instruction;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
        // The trap word itself flows downstream; only the PC freezes.
        if (instruction[31:26] == HALT_OPCODE) begin
          state_d = HALTED;
        end else begin
          pc_d = pc_plus4;
        end
      end else begin
        instr_d = NOP_INSTR;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
      end
    end
  end

  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pcp4_q;
  assign if_id_valid    = valid_q;
  assign halted         = (state_q == HALTED);
  assign fetch_count    = count_q;

endmodule
